// File: rtl/pwm_regbank.sv
// Register bank driving 16 output pins as static levels or a shared PWM waveform.
// Duty changes take effect only at PWM period boundaries; enable changes apply immediately.
module pwm_regbank #(
  parameter int CLK_DIV  = 13,
  parameter int MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic       period_start
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [6:0] ADDR_LAST = 7'(MAX_ADDR);

  logic [15:0] r_en_out;
  logic [15:0] r_en_pwm;
  logic [7:0]  r_duty;
  logic [7:0]  r_duty_active;
  logic [7:0]  r_prescale;
  logic [7:0]  r_pwm_cnt;
  logic [15:0] r_out;
  logic        r_period_start;

  logic        w_tick;
  logic        w_wrap;
  logic        w_wr_ok;
  logic        w_pwm_sig;
  logic [15:0] w_out_next;

  assign w_tick    = (r_prescale == DIV_LAST);
  assign w_wrap    = w_tick && (r_pwm_cnt == 8'hFF);
  assign w_wr_ok   = wr_valid && (wr_addr <= ADDR_LAST);
  assign w_pwm_sig = (r_duty_active == 8'hFF) || (r_pwm_cnt < r_duty_active);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_out <= '0;
      r_en_pwm <= '0;
      r_duty   <= '0;
    end else if (w_wr_ok) begin
      case (wr_addr)
        7'd0:    r_en_out[7:0]  <= wr_data;
        7'd1:    r_en_out[15:8] <= wr_data;
        7'd2:    r_en_pwm[7:0]  <= wr_data;
        7'd3:    r_en_pwm[15:8] <= wr_data;
        7'd4:    r_duty         <= wr_data;
        default: ;
      endcase
    end
  end

  // Shadow load samples the old r_duty, so a duty write landing on the wrap edge waits a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale     <= '0;
      r_pwm_cnt      <= '0;
      r_duty_active  <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_prescale     <= w_tick ? 8'd0 : r_prescale + 8'd1;
      r_period_start <= w_wrap;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
      if (w_wrap) begin
        r_duty_active <= r_duty;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pin
      assign w_out_next[gi] = r_en_out[gi] & (~r_en_pwm[gi] | w_pwm_sig);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_out_next;
    end
  end

  assign uo_out       = r_out[7:0];
  assign uio_out      = r_out[15:8];
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_regbank.sv
// Directed self-checking bench for pwm_regbank with default CLK_DIV=13 (3328-clock period).
module tb_pwm_regbank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic       period_start;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;
  int highs;
  int len;
  int n;

  always #5 clk = ~clk;

  pwm_regbank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .uo_out       (uo_out),
    .uio_out      (uio_out),
    .period_start (period_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [6:0] addr, input logic [7:0] data);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
    wr_addr  = 7'($urandom);
    wr_data  = 8'($urandom);
    $display("write addr=0x%02h data=0x%02h", addr, data);
  endtask

  task automatic wait_ps(input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!period_start && k < 4000);
    check(tag, 32'(period_start), 32'd1);
  endtask

  // Counts uo_out[0] highs from the sample after one period_start through the next one.
  task automatic measure(output int h, output int l);
    h = 0;
    l = 0;
    do begin
      tick();
      l++;
      if (uo_out[0]) h++;
    end while (!period_start && l < 4000);
  endtask

  initial begin
    repeat (3) tick();
    check("reset_uo", 32'(uo_out), 32'h00);
    check("reset_uio", 32'(uio_out), 32'h00);
    check("reset_ps", 32'(period_start), 32'd0);
    rst_n = 1'b1;

    write_reg(7'h00, 8'hA5);
    check("en_lo_latency", 32'(uo_out), 32'h00);
    tick();
    check("en_lo", 32'(uo_out), 32'hA5);
    write_reg(7'h01, 8'h3C);
    check("en_hi_latency", 32'(uio_out), 32'h00);
    tick();
    check("en_hi", 32'(uio_out), 32'h3C);

    wr_addr = 7'h00;
    wr_data = 8'h00;
    repeat (5) tick();
    check("novalid_uo", 32'(uo_out), 32'hA5);
    check("novalid_uio", 32'(uio_out), 32'h3C);

    write_reg(7'h05, 8'hFF);
    write_reg(7'h7F, 8'hFF);
    repeat (2) tick();
    check("badaddr_uo", 32'(uo_out), 32'hA5);
    check("badaddr_uio", 32'(uio_out), 32'h3C);

    write_reg(7'h02, 8'h01);
    tick();
    check("pwm_sel_duty0", 32'(uo_out), 32'hA4);

    write_reg(7'h04, 8'h80);
    wait_ps("ps_seen_50");
    measure(highs, len);
    check("duty50_high", 32'(highs), 32'd1664);
    check("duty50_len", 32'(len), 32'd3328);
    check("static_bits", 32'(uo_out & 8'hFE), 32'hA4);
    check("static_uio", 32'(uio_out), 32'h3C);

    repeat (3327) tick();
    check("prewrap_ps", 32'(period_start), 32'd0);
    wr_valid = 1'b1;
    wr_addr  = 7'h04;
    wr_data  = 8'h40;
    tick();
    wr_valid = 1'b0;
    $display("write addr=0x04 data=0x40 on wrap edge");
    check("wrap_align_ps", 32'(period_start), 32'd1);
    measure(highs, len);
    check("wrap_old_duty_high", 32'(highs), 32'd1664);
    check("wrap_old_duty_len", 32'(len), 32'd3328);
    measure(highs, len);
    check("wrap_new_duty_high", 32'(highs), 32'd832);
    check("wrap_new_duty_len", 32'(len), 32'd3328);

    write_reg(7'h04, 8'hFF);
    wait_ps("ps_seen_ff");
    measure(highs, len);
    check("duty_ff_high", 32'(highs), 32'd3328);
    check("duty_ff_len", 32'(len), 32'd3328);
    write_reg(7'h04, 8'h00);
    wait_ps("ps_seen_00");
    measure(highs, len);
    check("duty_00_high", 32'(highs), 32'd0);
    check("duty_00_len", 32'(len), 32'd3328);

    write_reg(7'h04, 8'h80);
    wait_ps("ps_seen_pre_reset");
    repeat (100) tick();
    check("pre_reset_high", 32'(uo_out[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_uo", 32'(uo_out), 32'h00);
    check("async_rst_uio", 32'(uio_out), 32'h00);
    check("async_rst_ps", 32'(period_start), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    $display("reset released");
    tick();
    check("release_uo", 32'(uo_out), 32'h00);
    check("release_uio", 32'(uio_out), 32'h00);
    n = 1;
    while (!period_start && n < 4000) begin
      tick();
      n++;
    end
    check("first_ps_delay", 32'(n), 32'd3328);

    write_reg(7'h00, 8'h01);
    tick();
    check("en_pwm_cleared", 32'(uo_out), 32'h01);
    write_reg(7'h02, 8'h01);
    tick();
    check("duty_cleared", 32'(uo_out), 32'h00);
    check("en_hi_cleared", 32'(uio_out), 32'h00);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/pwm_regbank.md
PWM_REGBANK -- requirements
Module: pwm_regbank

Interface
REQ-001 SHALL have parameter CLK_DIV, default 13, meaning system clocks per PWM counter step (legal range 1..255).
REQ-002 SHALL have parameter MAX_ADDR, default 4, meaning highest writable register address.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  single-cycle write strobe from SPI peripheral.
REQ-006 SHALL have port wr_addr  input  7  register address.
REQ-007 SHALL have port wr_data  input  8  register write data.
REQ-008 SHALL have port uo_out  output  8  output pins 7:0.
REQ-009 SHALL have port uio_out  output  8  output pins 15:8.
REQ-010 SHALL have port period_start  output  1  one-cycle pulse at the start of each PWM period.

Function
REQ-011 SHALL hold five 8-bit registers: 0x00 en_out_lo, 0x01 en_out_hi, 0x02 en_pwm_lo, 0x03 en_pwm_hi, 0x04 duty.
REQ-012 SHALL write wr_data into the addressed register on the clock edge where wr_valid=1 and wr_addr<=MAX_ADDR.
REQ-013 SHALL ignore writes with wr_addr>MAX_ADDR, with no state change.
REQ-014 SHALL, when wr_valid=0, ignore wr_addr and wr_data.
REQ-015 SHALL run a prescaler counting 0..CLK_DIV-1 and wrapping to 0; the cycle where it equals CLK_DIV-1 is a step tick.
REQ-016 SHALL run an 8-bit pwm_cnt that increments on each step tick and wraps 255->0; period = 256*CLK_DIV clocks.
REQ-017 SHALL keep a duty_active shadow register, loaded from duty only on the step tick where pwm_cnt wraps 255->0.
REQ-018 SHALL, when a duty write and the wrap coincide, load the pre-write duty value into duty_active; the new value applies from the following period.
REQ-019 SHALL assert period_start for exactly the one clock after that wrap, i.e. the first clock with pwm_cnt=0 and the new duty_active.
REQ-020 SHALL define pwm_sig = 1 when duty_active=0xFF, else (pwm_cnt < duty_active); duty_active=0x00 gives a constant 0.
REQ-021 SHALL drive, for bit i of 0..15: out[i] = 0 if en_out[i]=0; 1 if en_out[i]=1 and en_pwm[i]=0; pwm_sig if both are 1.
REQ-022 SHALL map out[7:0] to uo_out and out[15:8] to uio_out.
REQ-023 SHALL register all outputs, so an output changes exactly one clock after the cause (register write or counter state).
REQ-024 SHALL apply en_out and en_pwm writes immediately, without waiting for a period boundary.
REQ-025 SHALL keep the prescaler and pwm_cnt free-running regardless of register contents.

Reset
REQ-026 SHALL, while rst_n=0, clear all five registers, duty_active, prescaler, pwm_cnt, uo_out, uio_out and period_start to 0 asynchronously.
REQ-027 SHALL restart from prescaler=0, pwm_cnt=0 after reset release.
REQ-028 SHALL, on reset assertion mid-period, drop every output to 0 within the same cycle, with no glitch back to old values after release.
REQ-029 SHALL NOT assert period_start for the initial pwm_cnt=0 after reset; the first pulse follows the first 255->0 wrap.

Verification
REQ-030 Static enable: write 0x00=0xA5, 0x01=0x3C -> uo_out=0xA5, uio_out=0x3C one clock after each write; outputs stay stable for the rest of the test.
REQ-031 Duty 50%: en_out_lo=0x01, en_pwm_lo=0x01, duty=0x80, CLK_DIV=13 -> uo_out[0] high 128*13=1664 clocks and low 1664 of each 3328-clock period, starting the period after the write.
REQ-032 Duty extremes: duty=0x00 -> pwm bit constant 0; duty=0xFF -> constant 1 for full periods, no single-cycle low.
REQ-033 Invalid address: write addr 0x05 and 0x7F with data 0xFF -> no register or output change.
REQ-034 Boundary: write duty=0x40 on the exact wrap cycle while duty=0x80 -> the next period still runs at 0x80; the one after runs at 0x40; period_start pulses once per 3328 clocks.
REQ-035 Reset mid-operation: assert rst_n low during a PWM high phase -> all outputs 0 immediately; after release, all registers read as 0 and the first period_start occurs 3328 clocks later.
